// File: rtl/seq_div_32.sv
// Multi-cycle signed restoring divider (quotient/remainder) with start/busy/done handshake.
// Optional abort input enabled by defining SEQ_DIV_ABORT_EN.
module seq_div_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic             neg_a, neg_b, dz;
    logic [WIDTH:0]   shifted, diff;
    logic             fits;
    logic             kill;

`ifdef SEQ_DIV_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Partial remainder never exceeds the divisor magnitude, so one extra bit covers the shift.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvsr};
    assign fits    = (shifted >= {1'b0, dvsr});

    assign busy = (state == RUN) || (state == FIX);

    always_comb begin
        next = state;
        case (state)
            IDLE: if (start) next = (divisor == '0) ? DONE : RUN;
            RUN: begin
                if (kill)                      next = IDLE;
                else if (cnt == CW'(WIDTH-1))  next = FIX;
            end
            FIX:  next = kill ? IDLE : DONE;
            DONE: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvsr        <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= next;
            // done is registered off DONE, so the pulse lands the cycle after DONE.
            done  <= (state == DONE);
            case (state)
                IDLE: if (start) begin
                    quo         <= mag(dividend);
                    rem         <= '0;
                    dvsr        <= mag(divisor);
                    neg_a       <= dividend[WIDTH-1];
                    neg_b       <= divisor[WIDTH-1];
                    dz          <= (divisor == '0);
                    div_by_zero <= 1'b0;
                    cnt         <= '0;
                end
                RUN: if (!kill) begin
                    rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], fits};
                    cnt <= cnt + 1'b1;
                end
                FIX: if (!kill) begin
                    quotient  <= (neg_a ^ neg_b) ? -quo : quo;
                    remainder <= neg_a ? -rem : rem;
                end
                DONE: if (dz) begin
                    // quo still holds |dividend| here; restore the original sign.
                    quotient    <= '1;
                    remainder   <= neg_a ? -quo : quo;
                    div_by_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_32.sv
// Directed, table-driven bench for seq_div_32: results, latency, busy span and control corners.
module tb_seq_div_32;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         abort;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int ncmp = 0;
    int nerr = 0;

    seq_div_32 #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .start(start),
        .dividend(dividend), .divisor(divisor),
`ifdef SEQ_DIV_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Pulses start for one edge; returns at the negedge right after the accepting edge.
    task automatic kick(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // lat = edges after the accepting edge until done is seen; -1 on timeout.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int n = 0; n < 200; n++) begin
            if (n > 0) @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat, bcnt, dcnt;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{-32'sd100,      32'd7,          -32'sd14,       -32'sd2,        1'b0};
        vecs[2]  = '{32'd100,        -32'sd7,        -32'sd14,       32'd2,          1'b0};
        vecs[3]  = '{-32'sd100,      -32'sd7,        32'd14,         -32'sd2,        1'b0};
        vecs[4]  = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
        vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        vecs[6]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[7]  = '{32'd7,          32'd100,        32'd0,          32'd7,          1'b0};
        vecs[8]  = '{-32'sd7,        32'd0,          32'hFFFF_FFFF,  -32'sd7,        1'b1};
        vecs[9]  = '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  1'b0};
        vecs[10] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0};
        vecs[11] = '{32'd1000000,    -32'sd3,        -32'sd333333,   32'd1,          1'b0};
        vecs[12] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0};

        clr = 1'b1; start = 1'b0; abort = 1'b0; dividend = '0; divisor = '0;
        #12;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 13; i++) begin
            kick(vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            chk($sformatf("v%0d latency", i), lat, vecs[i].dz ? 32'd1 : 32'd34);
            chk($sformatf("v%0d busy cycles", i), bcnt, vecs[i].dz ? 32'd0 : 32'd33);
            chk($sformatf("v%0d quotient", i), quotient, vecs[i].q);
            chk($sformatf("v%0d remainder", i), remainder, vecs[i].r);
            chk($sformatf("v%0d dz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dz});
            @(negedge clk);
            chk($sformatf("v%0d done pulse width", i), {31'd0, done}, 32'd0);
        end

        // start re-pulsed mid-run with new operands is ignored
        kick(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("repulse latency ok", {31'd0, lat > 0}, 32'd1);
        chk("repulse quotient", quotient, 32'd14);
        chk("repulse remainder", remainder, 32'd2);
        kick(32'd9, 32'd3);
        wait_done(lat, bcnt);
        chk("after quotient", quotient, 32'd3);
        chk("after remainder", remainder, 32'd0);
        @(negedge clk);

`ifdef SEQ_DIV_ABORT_EN
        kick(32'd100, 32'd7);
        repeat (14) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort no done", dcnt, 32'd0);
        chk("abort quotient held", quotient, 32'd3);
        chk("abort remainder held", remainder, 32'd0);
        chk("abort dz held", {31'd0, div_by_zero}, 32'd0);
`endif

        // asynchronous clear mid-run
        kick(32'd100, 32'd7);
        repeat (14) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("clr busy", {31'd0, busy}, 32'd0);
        chk("clr done", {31'd0, done}, 32'd0);
        chk("clr quotient", quotient, 32'd0);
        chk("clr remainder", remainder, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("clr stays idle", dcnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
